// File: rtl/fp_add_norm_pack.sv
// fp_add_norm_pack: back end of the single-precision add/sub datapath.
// Takes the raw significand-adder sum with guard/round/sticky bits, normalizes
// it one bit per cycle, rounds to nearest-even and packs the IEEE-754 word
// together with the exception flags. One operation is in flight at a time.
module fp_add_norm_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int SUM_W  = FRAC_W + 5,
  parameter int RES_W  = 1 + EXP_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_r,
  input  logic [EXP_W-1:0] exp_r,
  input  logic [SUM_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  // Exponent carries two extra bits so carry shifts past the field range and
  // the overflow compare never wrap.
  localparam logic [EXP_W+1:0] E_ONE = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [EXP_W+1:0] E_MAX = {2'b00, {EXP_W{1'b1}}};

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   m_q, m_d;
  logic [EXP_W+1:0]   e_q, e_d;
  logic               sign_q, sign_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               inexact_q, inexact_d;
  logic               zero_q, zero_d;

  logic               lsbR, gR, rR, sR, upR, carryR, hidR, inexR, ovfR;
  logic [SUM_W-4:0]   rnd;
  logic [FRAC_W-1:0]  fracR;
  logic [EXP_W+1:0]   eR;
  logic [EXP_W-1:0]   fieldR;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;
  assign zero      = zero_q;

  // Round-to-nearest-even on the normalized significand and exponent/field selection.
  always_comb begin
    lsbR   = m_q[3];
    gR     = m_q[2];
    rR     = m_q[1];
    sR     = m_q[0];
    upR    = gR & (rR | sR | lsbR);
    rnd    = m_q[SUM_W-1:3] + {{(SUM_W-4){1'b0}}, upR};
    carryR = rnd[SUM_W-4];
    fracR  = carryR ? rnd[FRAC_W:1] : rnd[FRAC_W-1:0];
    hidR   = carryR | rnd[FRAC_W];
    eR     = e_q + {{(EXP_W+1){1'b0}}, carryR};
    inexR  = gR | rR | sR;
    ovfR   = (eR >= E_MAX);
    fieldR = hidR ? eR[EXP_W-1:0] : '0;
  end

  // Next-state logic: accept, iterative normalization, rounding/packing, output hold.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    e_d         = e_q;
    sign_d      = sign_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d         = sum;
          e_d         = {2'b00, exp_r};
          sign_d      = sign_r;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = 1'b0;
          zero_d      = 1'b0;
          if (sum == '0) begin
            result_d = {sign_r, {(RES_W-1){1'b0}}};
            zero_d   = 1'b1;
            state_d  = OUT;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (m_q[SUM_W-1]) begin
          m_d = {1'b0, m_q[SUM_W-1:1]} | {{(SUM_W-1){1'b0}}, m_q[0]};
          e_d = e_q + E_ONE;
        end else if (!m_q[SUM_W-2] && (e_q > E_ONE)) begin
          m_d = m_q << 1;
          e_d = e_q - E_ONE;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        e_d     = eR;
        zero_d  = 1'b0;
        state_d = OUT;
        if (ovfR) begin
          result_d    = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          overflow_d  = 1'b1;
          inexact_d   = 1'b1;
          underflow_d = 1'b0;
        end else begin
          result_d    = {sign_q, fieldR, fracR};
          overflow_d  = 1'b0;
          inexact_d   = inexR;
          underflow_d = (fieldR == '0) & inexR;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      e_q         <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_fp_add_norm_pack.sv
// tb_fp_add_norm_pack: directed bench for fp_add_norm_pack. Expected results are
// queued when an operation is accepted and compared when out_valid appears.
module tb_fp_add_norm_pack;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SUM_W  = FRAC_W + 5;
  localparam int RES_W  = 1 + EXP_W + FRAC_W;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    logic        zro;
    int          lat;
  } expect_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             sign_r;
  logic [EXP_W-1:0] exp_r;
  logic [SUM_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;
  logic             overflow;
  logic             underflow;
  logic             inexact;
  logic             zero;

  expect_t sbQ[$];
  int numVectors = 0;
  int numMiscompares = 0;

  fp_add_norm_pack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_r    (sign_r),
    .exp_r     (exp_r),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic compareVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numVectors++;
    assert (observed === expected) else begin
      numMiscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic noteTimeout(input string tag);
    numVectors++;
    numMiscompares++;
    $display("[TB] FAIL %s: observed timeout expected event", tag);
  endtask

  // Drive one operation, wait for the accept edge and queue its expectation.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [27:0] sm,
                               input logic [31:0] res, input logic ovf, input logic unf,
                               input logic inx, input logic zro, input int lat);
    expect_t x;
    int waitCnt;
    @(negedge clk);
    sign_r   = s;
    exp_r    = e;
    sum      = sm;
    in_valid = 1'b1;
    waitCnt  = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      noteTimeout("accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x.res = res; x.ovf = ovf; x.unf = unf; x.inx = inx; x.zro = zro; x.lat = lat;
    sbQ.push_back(x);
    compareVal("in_ready_busy", {31'b0, in_ready}, 32'd0);
  endtask

  // Wait for the result, compare it with the queue head, optionally stall, then drain.
  task automatic checkOutput(input int holdCycles);
    expect_t x;
    int lat;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      noteTimeout("out_valid");
      return;
    end
    if (sbQ.size() == 0) begin
      noteTimeout("scoreboard_empty");
      return;
    end
    x = sbQ.pop_front();
    compareVal("latency",   lat,              x.lat);
    compareVal("result",    result,           x.res);
    compareVal("overflow",  {31'b0, overflow},  {31'b0, x.ovf});
    compareVal("underflow", {31'b0, underflow}, {31'b0, x.unf});
    compareVal("inexact",   {31'b0, inexact},   {31'b0, x.inx});
    compareVal("zero",      {31'b0, zero},      {31'b0, x.zro});
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      compareVal("hold_result",    result,              x.res);
      compareVal("hold_out_valid", {31'b0, out_valid},  32'd1);
      compareVal("hold_in_ready",  {31'b0, in_ready},   32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    compareVal("drop_out_valid", {31'b0, out_valid}, 32'd0);
    compareVal("back_to_idle",   {31'b0, in_ready},  32'd1);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    sign_r    = 1'b0;
    exp_r     = '0;
    sum       = '0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] checking reset state");
    compareVal("rst_in_ready",  {31'b0, in_ready},  32'd1);
    compareVal("rst_out_valid", {31'b0, out_valid}, 32'd0);
    compareVal("rst_result",    result,             32'd0);
    compareVal("rst_flags",     {28'b0, overflow, underflow, inexact, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry-out: one right shift.
    applyStimulus(1'b0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 0, 0, 3);
    checkOutput(0);
    // Massive cancellation: 23 left shifts.
    applyStimulus(1'b0, 8'd130, 28'h0000008, 32'h35800000, 0, 0, 0, 0, 25);
    checkOutput(0);
    // Round up on lsb=1, then round-half-even tie stays.
    applyStimulus(1'b0, 8'd127, 28'h400000C, 32'h3F800002, 0, 0, 1, 0, 2);
    checkOutput(0);
    applyStimulus(1'b0, 8'd127, 28'h4000004, 32'h3F800000, 0, 0, 1, 0, 2);
    checkOutput(0);
    // Overflow to infinity and an exact denormal.
    applyStimulus(1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1, 0, 1, 0, 3);
    checkOutput(0);
    applyStimulus(1'b0, 8'd1, 28'h0000010, 32'h00000002, 0, 0, 0, 0, 2);
    checkOutput(0);
    // Exact zero, visible right after accept, then five stalled cycles.
    applyStimulus(1'b0, 8'd5, 28'h0000000, 32'h00000000, 0, 0, 0, 1, 0);
    checkOutput(5);
    // Negative sign passes through.
    applyStimulus(1'b1, 8'd127, 28'h4000000, 32'hBF800000, 0, 0, 0, 0, 2);
    checkOutput(0);
    // Rounding carries out of the significand and bumps the exponent.
    applyStimulus(1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 0, 0, 1, 0, 2);
    checkOutput(0);
    // Denormal rounds up into the hidden bit and packs with field 1.
    applyStimulus(1'b0, 8'd1, 28'h3FFFFFC, 32'h00800000, 0, 0, 1, 0, 2);
    checkOutput(0);
    // Inexact denormal raises underflow.
    applyStimulus(1'b0, 8'd1, 28'h0000014, 32'h00000002, 0, 1, 1, 0, 2);
    checkOutput(0);
    // Left shift stops once the exponent reaches 1.
    applyStimulus(1'b0, 8'd3, 28'h0000008, 32'h00000004, 0, 0, 0, 0, 4);
    checkOutput(0);
    // Bit shifted out by the carry normalization lands in sticky.
    applyStimulus(1'b0, 8'd127, 28'h8000001, 32'h40000000, 0, 0, 1, 0, 3);
    checkOutput(0);

    // Reset in the middle of a long normalization.
    $display("[TB] reset during normalization");
    @(negedge clk);
    sign_r   = 1'b0;
    exp_r    = 8'd130;
    sum      = 28'h0000008;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    compareVal("norm_busy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    compareVal("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    compareVal("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    compareVal("midrst_result",    result,             32'd0);
    compareVal("midrst_flags",     {28'b0, overflow, underflow, inexact, zero}, 32'd0);
    compareVal("midrst_sb_empty",  sbQ.size(),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 0, 0, 3);
    checkOutput(0);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
